// File: rtl/eth_pkt_slot_writer_if.sv
// rtl/eth_pkt_slot_writer_if.sv - signal bundle between the MAC byte stream, packet RAM, ecpri_rx and eth_pkt_slot_writer
// Purpose: groups every non-clock/reset signal of eth_pkt_slot_writer.
// Ports:
//   stream     in_valid, in_data, in_sop, in_eop           (master -> slave)
//   ram write  ram_addr, ram_data, ram_cs, ram_we, ram_oe  (slave -> master)
//   descriptor desc_valid, desc_slot, desc_len (slave -> master); desc_ready, rel (master -> slave)
//   status     free_slots, drop_full_cnt, drop_err_cnt     (slave -> master)
interface eth_pkt_slot_writer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int SLOT_LOG2  = 2,
  parameter int SLOT_AW    = 11
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_sop;
  logic                  in_eop;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ram_cs;
  logic                  ram_we;
  logic                  ram_oe;
  logic                  desc_valid;
  logic [SLOT_LOG2-1:0]  desc_slot;
  logic [SLOT_AW:0]      desc_len;
  logic                  desc_ready;
  logic                  rel;
  logic [SLOT_LOG2:0]    free_slots;
  logic [15:0]           drop_full_cnt;
  logic [15:0]           drop_err_cnt;

  modport master (
    output in_valid, in_data, in_sop, in_eop, desc_ready, rel,
    input  ram_addr, ram_data, ram_cs, ram_we, ram_oe,
           desc_valid, desc_slot, desc_len, free_slots, drop_full_cnt, drop_err_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, desc_ready, rel,
    output ram_addr, ram_data, ram_cs, ram_we, ram_oe,
           desc_valid, desc_slot, desc_len, free_slots, drop_full_cnt, drop_err_cnt
  );
endinterface

// File: rtl/eth_pkt_slot_writer.sv
// rtl/eth_pkt_slot_writer.sv - writes MAC frames into fixed-size packet-RAM slots and hands out descriptors
// Purpose: each frame goes to the next free slot; committed frames are announced as {slot, len}
//          descriptors and the slot stays occupied until rel. Runt, oversize, aborted frames and
//          frames arriving with no free slot are dropped and counted.
// Ports:
//   clk   rising-edge clock
//   reset asynchronous, active-high
//   bus   eth_pkt_slot_writer_if.slave (stream in, RAM write port, descriptor, status)
module eth_pkt_slot_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int SLOT_LOG2  = 2,
  parameter int SLOT_AW    = 11,
  parameter int MIN_LEN    = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  eth_pkt_slot_writer_if.slave bus
);
  localparam int NUM_SLOTS = 2**SLOT_LOG2;
  localparam int LW        = SLOT_AW + 1;
  localparam int OW        = SLOT_LOG2 + 1;
  localparam logic [LW-1:0] SLOT_DEPTH = {1'b1, {SLOT_AW{1'b0}}};
  localparam logic [LW-1:0] MIN_LEN_L  = LW'(MIN_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DROP} state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         count_q, count_d;
  logic [SLOT_LOG2-1:0]  wr_slot_q, wr_slot_d;
  logic [SLOT_LOG2-1:0]  rd_slot_q, rd_slot_d;
  logic [SLOT_LOG2-1:0]  rel_slot_q, rel_slot_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic [OW-1:0]         qcnt_q, qcnt_d;
  logic                  push_q, push_d;
  logic [SLOT_LOG2-1:0]  push_slot_q, push_slot_d;
  logic [LW-1:0]         push_len_q, push_len_d;
  logic [LW-1:0]         len_mem_q [NUM_SLOTS];
  logic [LW-1:0]         len_mem_d [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  ram_we_q, ram_we_d;
  logic [15:0]           full_cnt_q, full_cnt_d;
  logic [15:0]           err_cnt_q, err_cnt_d;

  logic          start, eof, commit, full_inc, rel_ok, pop;
  logic [1:0]    err_inc;
  logic [LW-1:0] eof_len;
  logic [16:0]   err_sum;

  // Frame FSM and RAM write port.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_slot_d  = wr_slot_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    full_inc   = 1'b0;
    err_inc    = 2'd0;
    start      = 1'b0;
    eof        = 1'b0;
    eof_len    = count_q;
    commit     = 1'b0;
    if (bus.in_valid) begin
      if (bus.in_sop) begin
        // sop mid-frame abandons the slot contents; the slot itself is reused
        if (state_q == ST_WRITE) err_inc = err_inc + 2'd1;
        start = 1'b1;
      end else if (state_q == ST_WRITE) begin
        if (count_q == SLOT_DEPTH) begin
          err_inc = err_inc + 2'd1;
          state_d = bus.in_eop ? ST_IDLE : ST_DROP;
        end else begin
          ram_we_d   = 1'b1;
          ram_addr_d = ADDR_WIDTH'({wr_slot_q, count_q[SLOT_AW-1:0]});
          ram_data_d = bus.in_data;
          count_d    = count_q + LW'(1);
          eof        = bus.in_eop;
          eof_len    = count_q + LW'(1);
        end
      end else if (state_q == ST_DROP && bus.in_eop) begin
        state_d = ST_IDLE;
      end
    end
    if (start) begin
      // the slot being written (if any) was just abandoned, so only committed slots matter
      if (occ_q < OW'(NUM_SLOTS)) begin
        ram_we_d   = 1'b1;
        ram_addr_d = ADDR_WIDTH'({wr_slot_q, {SLOT_AW{1'b0}}});
        ram_data_d = bus.in_data;
        count_d    = LW'(1);
        state_d    = ST_WRITE;
        eof        = bus.in_eop;
        eof_len    = LW'(1);
      end else begin
        full_inc = 1'b1;
        state_d  = bus.in_eop ? ST_IDLE : ST_DROP;
      end
    end
    if (eof) begin
      state_d = ST_IDLE;
      if (eof_len < MIN_LEN_L) err_inc = err_inc + 2'd1;
      else                     commit  = 1'b1;
    end
    if (commit) wr_slot_d = wr_slot_q + SLOT_LOG2'(1);
  end

  // Occupancy, descriptor queue and drop counters. Commits arrive in slot order, so the
  // queue is held as one length per slot and rd_slot doubles as the queue read pointer.
  // The push is delayed one cycle so the descriptor appears after the last RAM write.
  always_comb begin
    rel_ok      = bus.rel && (occ_q != '0);
    pop         = (qcnt_q != '0) && bus.desc_ready;
    occ_d       = occ_q + OW'(commit) - OW'(rel_ok);
    rel_slot_d  = rel_slot_q + SLOT_LOG2'(rel_ok);
    push_d      = commit;
    push_slot_d = wr_slot_q;
    push_len_d  = eof_len;
    len_mem_d   = len_mem_q;
    if (push_q) len_mem_d[push_slot_q] = push_len_q;
    qcnt_d      = qcnt_q + OW'(push_q) - OW'(pop);
    rd_slot_d   = rd_slot_q + SLOT_LOG2'(pop);
    full_cnt_d  = (full_cnt_q == 16'hFFFF) ? full_cnt_q : full_cnt_q + 16'(full_inc);
    err_sum     = {1'b0, err_cnt_q} + 17'(err_inc);
    err_cnt_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      wr_slot_q   <= '0;
      rd_slot_q   <= '0;
      rel_slot_q  <= '0;
      occ_q       <= '0;
      qcnt_q      <= '0;
      push_q      <= 1'b0;
      push_slot_q <= '0;
      push_len_q  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) len_mem_q[i] <= '0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_we_q    <= 1'b0;
      full_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_slot_q   <= wr_slot_d;
      rd_slot_q   <= rd_slot_d;
      rel_slot_q  <= rel_slot_d;
      occ_q       <= occ_d;
      qcnt_q      <= qcnt_d;
      push_q      <= push_d;
      push_slot_q <= push_slot_d;
      push_len_q  <= push_len_d;
      len_mem_q   <= len_mem_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_we_q    <= ram_we_d;
      full_cnt_q  <= full_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.ram_addr      = ram_addr_q;
  assign bus.ram_data      = ram_data_q;
  assign bus.ram_cs        = ram_we_q;
  assign bus.ram_we        = ram_we_q;
  assign bus.ram_oe        = 1'b0;
  assign bus.desc_valid    = (qcnt_q != '0);
  assign bus.desc_slot     = rd_slot_q;
  assign bus.desc_len      = len_mem_q[rd_slot_q];
  assign bus.free_slots    = OW'(NUM_SLOTS) - occ_q - OW'(state_q == ST_WRITE);
  assign bus.drop_full_cnt = full_cnt_q;
  assign bus.drop_err_cnt  = err_cnt_q;
endmodule

// File: doc/eth_pkt_slot_writer.md
# eth_pkt_slot_writer

Synthesizable successor to the bench-side byte loader that fills the received-Ethernet-packet RAM for `ecpri_rx`. It takes a MAC-side byte stream and writes each frame into one of `NUM_SLOTS` fixed-size slots of the dual-port packet RAM. It then presents a descriptor (slot, length) to `ecpri_rx`. Slots are freed by an explicit release, and frames that are too short, too long, malformed or arrive while all slots are busy are dropped and counted.

## Interface
- `DATA_WIDTH`, 8: RAM/stream byte width.
- `ADDR_WIDTH`, 16: RAM address width; must be ≥ `SLOT_AW + SLOT_LOG2`.
- `SLOT_LOG2`, 2: log2 of slot count; `NUM_SLOTS = 2**SLOT_LOG2`.
- `SLOT_AW`, 11: log2 of slot depth in bytes; slot depth is 2048.
- `MIN_LEN`, 14: minimum accepted frame length in bytes (Ethernet header).
- Clock and reset:
  - `clk` in 1: single clock; everything is on the rising edge.
  - `reset` in 1: asynchronous, active-high.
- Input stream:
  - `in_valid` in 1: byte strobe. There is no backpressure.
  - `in_data` in `DATA_WIDTH`: frame byte.
  - `in_sop` in 1: first byte of a frame; qualified by `in_valid`.
  - `in_eop` in 1: last byte of a frame; qualified by `in_valid`.
- RAM write port (port 0 of `ram_dp_sr_sw`):
  - `ram_addr` out `ADDR_WIDTH`: `{zero pad, slot, offset}`.
  - `ram_data` out `DATA_WIDTH`: write data.
  - `ram_cs` out 1: chip select.
  - `ram_we` out 1: write enable.
  - `ram_oe` out 1: tied 0 (write-only).
- Descriptor to `ecpri_rx`:
  - `desc_valid` out 1: descriptor available.
  - `desc_slot` out `SLOT_LOG2`: slot holding the frame.
  - `desc_len` out `SLOT_AW+1`: frame length in bytes.
  - `desc_ready` in 1: consumer takes the descriptor.
  - `rel` in 1: one-cycle pulse that frees the oldest handed-out slot.
- Status:
  - `free_slots` out `SLOT_LOG2+1`: slots neither being written nor occupied.
  - `drop_full_cnt` out 16: frames dropped for lack of a slot; saturating.
  - `drop_err_cnt` out 16: runt, oversize and aborted frames; saturating.

## Operation
- Pointers, each `SLOT_LOG2` bits and wrapping modulo `NUM_SLOTS`:
  - `wr_slot`: slot currently or next being filled.
  - `rd_slot`: next descriptor to present.
  - `rel_slot`: next slot to free.
- Counter `occ` (0..`NUM_SLOTS`) counts committed slots that have not been released.
- `free_slots = NUM_SLOTS - occ - (state==WRITE)`.
- FSM states: IDLE, WRITE, DROP.
  - IDLE:
    - `in_valid & in_sop`:
      - If `free_slots>0`, write the byte at offset 0, set count to 1, and go to WRITE. If `in_eop` is also set, evaluate the end-of-frame rules immediately.
      - Otherwise increment `drop_full_cnt` and go to DROP (back to IDLE if `in_eop`).
    - `in_valid` without `in_sop`: byte ignored.
  - WRITE:
    - Each `in_valid` byte is written at offset = count, then count increments.
    - A byte arriving when count == 2**`SLOT_AW` is oversize: increment `drop_err_cnt`, go to DROP (IDLE if `in_eop`), and do not advance `wr_slot`.
    - `in_sop` mid-frame aborts the current frame: increment `drop_err_cnt`. The new byte is then handled exactly as in IDLE.
    - On `in_eop` with final length < `MIN_LEN`: increment `drop_err_cnt` and go to IDLE; the slot is reused.
    - On `in_eop` otherwise: commit the frame, i.e. push `{wr_slot, len}` into the descriptor queue (depth `NUM_SLOTS`), `occ++`, `wr_slot++`, go to IDLE.
  - DROP: bytes are discarded; `in_eop` returns to IDLE. `in_sop` is handled as in IDLE.
- Descriptor handshake:
  - `desc_valid` is high while the queue is non-empty, and `desc_slot`/`desc_len` show the head entry.
  - A pop happens when `desc_valid & desc_ready`.
  - Outputs stay stable until popped.
- Release:
  - `rel` with `occ>0` does `occ--` and `rel_slot++`.
  - `rel` with `occ==0` is ignored.
  - `rel` is honoured for any handed-out slot; the consumer must release in hand-out order.
- Simultaneous commit and release in one cycle: both apply, so `occ` is unchanged.
- Counters saturate at 16'hFFFF.

## Timing
- Reset (asynchronous): FSM IDLE; all pointers, `occ` and the queue cleared.
  - Outputs after reset: `ram_addr=0`, `ram_data=0`, `ram_cs=0`, `ram_we=0`, `ram_oe=0`, `desc_valid=0`, `desc_slot=0`, `desc_len=0`, `free_slots=NUM_SLOTS`, both counters 0.
  - Reset mid-frame abandons the frame; nothing is counted.
- RAM port is registered: a byte accepted at edge k drives `ram_cs=ram_we=1` with its address and data in the cycle after edge k.
- Latency: `desc_valid` rises in the cycle after the eop byte's RAM write cycle, i.e. 2 cycles after the eop byte is accepted, so the frame is fully in RAM before the descriptor appears.
- `free_slots` and the counters update one cycle after the causing event.
- Zero-bubble operation: back-to-back frames (eop in cycle n, sop in cycle n+1) are both accepted when slots are available.

## Test plan
- **Single frame.** 60-byte frame of bytes 0..59 after reset.
  - RAM gets writes to addr 0..59 with data 0..59.
  - `desc_valid`=1 with slot 0, len 60, 2 cycles after eop.
  - `free_slots` goes 4 → 3.
- **Slots full.** Five 64-byte frames back-to-back with no `desc_ready`/`rel`.
  - Slots 0..3 are filled at base addresses 0, 2048, 4096, 6144.
  - Fifth frame dropped: `drop_full_cnt`=1, no RAM writes for it.
  - After one `rel`, a sixth frame lands in slot 0.
- **Runt and oversize.**
  - 10-byte frame → `drop_err_cnt`=1, no descriptor.
  - 2049-byte frame → `drop_err_cnt`=2, no descriptor.
  - A following 14-byte frame reuses the same slot with len 14.
- **Abort.** `in_sop` at byte 30 of a frame, then a 40-byte frame.
  - `drop_err_cnt`=1.
  - Single descriptor with len 40, same slot.
- **Simultaneous commit and release.** `occ`=2, then `rel` is pulsed in the same cycle as a commit: `occ` stays 2 and `free_slots` stays 2.
- **Reset mid-frame.** Assert `reset` mid-frame, then send a 60-byte frame: the outputs return to their reset values immediately, and the new frame gets slot 0 with len 60.
